// File: rtl/ram_loader_controller.sv
// Streams bytes into the RAM manual-programming port, holding the CPU halted while loading.
// Optional read-back checksum verify pass enabled by defining RAM_VERIFY_EN.
module ram_loader_controller #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_halt,
  output logic                ram_manual_mode,
  output logic                ram_manual_read,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_program_switches,
  input  logic [DATA_W-1:0]   ram_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_loaded
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef RAM_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_load_addr;
  logic [DATA_W-1:0]   r_prog;
  logic [ADDR_W:0]     r_words;
  logic                w_start_ok;
  logic                w_last;

  assign w_start_ok = start && !abort;
  assign w_last     = (r_load_addr == LAST_ADDR);

`ifdef RAM_VERIFY_EN
  logic [DATA_W-1:0]   r_wsum;
  logic [DATA_W-1:0]   r_rsum;
  logic [DATA_W-1:0]   w_rd_total;
  logic                r_phase;
  logic                r_error;
  logic                w_sum_ok;

  assign w_rd_total = r_rsum + ram_data;
  assign w_sum_ok   = (w_rd_total == r_wsum);
  assign error      = r_error;
`else
  logic w_unused_ram_data;
  assign w_unused_ram_data = ^ram_data;
  assign error             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    s_ready         = 1'b0;
    cpu_halt        = 1'b1;
    ram_manual_mode = 1'b1;
    ram_manual_read = 1'b0;
    ram_address     = r_load_addr;
    busy            = 1'b1;
    done            = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_halt        = 1'b0;
        ram_manual_mode = 1'b0;
        ram_address     = cpu_addr;
        busy            = 1'b0;
        if (w_start_ok) w_next = S_RECV;
      end
      S_RECV: begin
        s_ready = 1'b1;
        if (abort)        w_next = S_IDLE;
        else if (s_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        ram_manual_read = 1'b1;
        if (abort)       w_next = S_IDLE;
`ifdef RAM_VERIFY_EN
        else if (w_last) w_next = S_VERIFY;
`else
        else if (w_last) w_next = S_DONE;
`endif
        else             w_next = S_RECV;
      end
`ifdef RAM_VERIFY_EN
      S_VERIFY: begin
        if (abort)                   w_next = S_IDLE;
        else if (r_phase && w_last)  w_next = w_sum_ok ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load address, latched byte, counters and (optionally) checksums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_addr <= START_ADDR;
      r_prog      <= '0;
      r_words     <= '0;
`ifdef RAM_VERIFY_EN
      r_wsum      <= '0;
      r_rsum      <= '0;
      r_phase     <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_load_addr <= START_ADDR;
            r_words     <= '0;
`ifdef RAM_VERIFY_EN
            r_wsum      <= '0;
            r_error     <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (s_valid && !abort) r_prog <= s_data;
        end
        S_WRITE: begin
          r_words <= r_words + (ADDR_W+1)'(1);
`ifdef RAM_VERIFY_EN
          r_wsum  <= r_wsum + r_prog;
          if (w_last) begin
            r_load_addr <= START_ADDR;
            r_rsum      <= '0;
            r_phase     <= 1'b0;
          end else begin
            r_load_addr <= r_load_addr + ADDR_W'(1);
          end
`else
          if (!w_last) r_load_addr <= r_load_addr + ADDR_W'(1);
`endif
        end
`ifdef RAM_VERIFY_EN
        // Each address is held two cycles so read data has settled before sampling.
        S_VERIFY: begin
          if (!abort) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              r_rsum <= w_rd_total;
              if (w_last) begin
                if (!w_sum_ok) r_error <= 1'b1;
              end else begin
                r_load_addr <= r_load_addr + ADDR_W'(1);
              end
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ram_program_switches = r_prog;
  assign words_loaded         = r_words;

endmodule
